vga_demo_sequencer: RTL and testbench
=====================================

Name: vga_demo_sequencer

Overview:
- Parametrised successor to the fixed 640x480 timing and frame-counter logic used by the demo cores.
- Generates VGA timing for any resolution and porch set, plus a frame/part/beat sequencer with pause, single-step and part-override controls.
- Includes an N-stage sync/RGB alignment pipeline, so effect logic can be registered without skewing pixels against sync.
- Sits between the top-level pin mapping and the per-part effect generators.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_NEG, 1, 1 = syncs active-low
- COORD_W, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1
- BPC, 2, bits per colour channel
- FRAME_W, 12, frame counter width (at least PART_W+6)
- PART_W, 3, number of part-select bits
- PIPE, 1, alignment stages from rgb_in to outputs (0..4)

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, reset; synchronous, active-low
- pause, in, 1, freeze frame counter at frame end
- step, in, 1, level input; a rising edge requests one frame advance while paused
- part_force_en, in, 1, override part output
- part_force, in, PART_W, forced part value
- rgb_in, in, 3*BPC, {R,G,B} from effect logic, computed from the current hpos/vpos
- hpos, out, COORD_W, current column (stage 0)
- vpos, out, COORD_W, current line (stage 0)
- display_on, out, 1, stage-0 visible flag
- frame_start, out, 1, one-cycle pulse at hpos=0, vpos=0
- frame, out, FRAME_W, frame counter
- part, out, PART_W, active part
- beat_phase, out, 2, frame[5:4]
- envelope, out, 5, 31 - 2*frame[3:0]
- hsync_o, out, 1, aligned hsync
- vsync_o, out, 1, aligned vsync
- rgb_o, out, 3*BPC, aligned and blanked RGB

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800 by default); V_TOTAL likewise (525 by default).
- Reset: rst_n is synchronous, active-low, on clk. Reset clears hpos, vpos, frame, step latch and every pipeline stage. In reset, syncs sit at their inactive level (1 when SYNC_NEG=1) and rgb_o=0.
- Horizontal counter: hpos increments every clk and wraps from H_TOTAL-1 to 0.
- Vertical counter: vpos increments on each hpos wrap and wraps from V_TOTAL-1 to 0.
- Stage-0 sync: hsync active for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on the vertical parameters.
- display_on = (hpos < H_ACTIVE) & (vpos < V_ACTIVE); combinational from the counters.
- Alignment pipeline:
  - rgb_in is sampled together with the stage-0 hsync/vsync/display_on and passed through PIPE register stages.
  - rgb_o = delayed display_on ? delayed rgb : 0.
  - PIPE=0 makes the outputs combinational.
  - Latency from counter state to pins is exactly PIPE cycles.
- Frame end: the cycle with hpos=H_TOTAL-1 and vpos=V_TOTAL-1.
- Frame advance:
  - At frame end, frame increments if pause=0, or if pause=1 and the step latch is set. An advance under pause clears the step latch.
  - frame wraps from 2^FRAME_W-1 to 0.
- Step latch:
  - Set by a step rising edge (registered edge detect).
  - Cleared on any cycle with pause=0, so steps while running are discarded.
  - Multiple edges within one paused frame still produce a single advance.
  - If a step edge and frame end fall on the same cycle while paused, the frame advances.
- part = part_force_en ? part_force : frame[FRAME_W-1 -: PART_W]. The override is combinational and does not alter frame.
- beat_phase and envelope are derived combinationally from frame. envelope runs 31, 29, … , 1.
- frame_start is stage 0, not delayed.
- Mid-frame reset: the next cycle after release shows hpos=0, vpos=0, frame_start=1 and frame=0.

Optional Feature:
- Macro: VGA_SEQ_SCANLINE_EN.
- Defined: on odd vpos (taken from the pipeline-delayed line parity), each colour channel of rgb_o is shifted right by 1. This gives a CRT scanline look.
- Undefined: rgb_o passes unmodified, and the parity register is omitted.

Decomposition:
- Package vga_seq_pkg holds:
  - default 640x480@60 timing constants;
  - an h_total/v_total computation function;
  - localparam names for the eight parts (PART_TITLE … PART_TITLE_TUNNEL);
  - the envelope constants.
- One sub-module, vga_timing_core: counters, stage-0 sync and display_on, frame_start.
- The sequencer and alignment pipeline stay in the top module.

Test Plan:
1. Reset for 3 cycles, then release -> hpos=0, vpos=0, frame=0. During reset, hsync_o=vsync_o=1 and rgb_o=0.
2. Default params, PIPE=1 -> hsync_o low from the cycle after hpos=656 for 96 cycles. vsync_o low across lines 490–491. rgb_o=0 whenever hpos≥640 (delayed).
3. Free run for 420000 cycles -> frame=1. Run 4096 frames -> part goes 7→0 and frame wraps to 0. envelope=31 at frame[3:0]=0 and 1 at frame[3:0]=15.
4. Set pause=1 and run 3 frames -> frame unchanged. Pulse step twice within one frame -> frame +1 only. Step pulse with pause=0 -> no extra increment.
5. part_force_en=1, part_force=5 at frame=0x100 -> part=5. Release -> part=frame[11:9]=0.
6. Assert rst_n=0 at hpos=300, vpos=200 -> next cycle after release shows hpos=0, vpos=0, frame_start=1. With VGA_SEQ_SCANLINE_EN, rgb_in=6'b11_11_11 gives rgb_o=6'b01_01_01 on odd lines.

Source files
------------

// File: rtl/vga_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | vga_seq_pkg: shared timing defaults, total helper, part names, envelope.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_seq_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam logic [2:0] PART_TITLE        = 3'd0;
  localparam logic [2:0] PART_PLASMA       = 3'd1;
  localparam logic [2:0] PART_BARS         = 3'd2;
  localparam logic [2:0] PART_STARS        = 3'd3;
  localparam logic [2:0] PART_ROTO         = 3'd4;
  localparam logic [2:0] PART_FIRE         = 3'd5;
  localparam logic [2:0] PART_SCROLL       = 3'd6;
  localparam logic [2:0] PART_TITLE_TUNNEL = 3'd7;

  localparam logic [4:0] ENV_TOP = 5'd31;
endpackage

`default_nettype wire

// File: rtl/vga_timing_core.sv
// +----------------------------------------------------------------------------+
// | vga_timing_core: h/v counters, stage-0 sync/display flags, frame markers.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_timing_core
  import vga_seq_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int COORD_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] o_hpos,
  output logic [COORD_W-1:0] o_vpos,
  output logic               o_hsync_act,
  output logic               o_vsync_act,
  output logic               o_display_on,
  output logic               o_frame_start,
  output logic               o_frame_end
);
  localparam logic [COORD_W-1:0] C_H_LAST   = COORD_W'(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [COORD_W-1:0] C_V_LAST   = COORD_W'(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [COORD_W-1:0] C_H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] C_V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] C_HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] C_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] C_VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] C_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] r_hpos;
  logic [COORD_W-1:0] r_vpos;
  logic               w_h_end;
  logic               w_v_end;

  assign w_h_end = (r_hpos == C_H_LAST);
  assign w_v_end = (r_vpos == C_V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (w_h_end) begin
      r_hpos <= '0;
      r_vpos <= w_v_end ? '0 : r_vpos + COORD_W'(1);
    end else begin
      r_hpos <= r_hpos + COORD_W'(1);
    end
  end

  assign o_hpos        = r_hpos;
  assign o_vpos        = r_vpos;
  assign o_hsync_act   = (r_hpos >= C_HS_START) && (r_hpos < C_HS_END);
  assign o_vsync_act   = (r_vpos >= C_VS_START) && (r_vpos < C_VS_END);
  assign o_display_on  = (r_hpos < C_H_ACT) && (r_vpos < C_V_ACT);
  assign o_frame_start = (r_hpos == '0) && (r_vpos == '0);
  assign o_frame_end   = w_h_end && w_v_end;
endmodule

`default_nettype wire

// File: rtl/vga_demo_sequencer.sv
// +----------------------------------------------------------------------------+
// | vga_demo_sequencer: VGA timing, frame/part/beat sequencer, sync/RGB align. |
// | Optional macro VGA_SEQ_SCANLINE_EN halves colour on odd lines. Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_demo_sequencer
  import vga_seq_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_NEG = 1,
  parameter int COORD_W  = 10,
  parameter int BPC      = 2,
  parameter int FRAME_W  = 12,
  parameter int PART_W   = 3,
  parameter int PIPE     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause,
  input  logic               step,
  input  logic               part_force_en,
  input  logic [PART_W-1:0]  part_force,
  input  logic [3*BPC-1:0]   rgb_in,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               display_on,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame,
  output logic [PART_W-1:0]  part,
  output logic [1:0]         beat_phase,
  output logic [4:0]         envelope,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [3*BPC-1:0]   rgb_o
);
  localparam int RGB_W = 3 * BPC;
`ifdef VGA_SEQ_SCANLINE_EN
  localparam int D_W = RGB_W + 4;
`else
  localparam int D_W = RGB_W + 3;
`endif

  logic               w_hs0;
  logic               w_vs0;
  logic               w_frame_end;
  logic [D_W-1:0]     w_s0;
  logic [D_W-1:0]     w_sn;
  logic [RGB_W-1:0]   w_rgb_vis;
  logic [RGB_W-1:0]   w_rgb_fin;
  logic               w_step_rise;
  logic               w_advance;
  logic               r_step_d;
  logic               r_step_lat;
  logic [FRAME_W-1:0] r_frame;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .COORD_W  (COORD_W)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_hpos        (hpos),
    .o_vpos        (vpos),
    .o_hsync_act   (w_hs0),
    .o_vsync_act   (w_vs0),
    .o_display_on  (display_on),
    .o_frame_start (frame_start),
    .o_frame_end   (w_frame_end)
  );

  // A step edge coinciding with frame end under pause still counts.
  assign w_step_rise = step & ~r_step_d;
  assign w_advance   = w_frame_end & (~pause | r_step_lat | w_step_rise);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step_d   <= 1'b0;
      r_step_lat <= 1'b0;
      r_frame    <= '0;
    end else begin
      r_step_d <= step;
      if (!pause)
        r_step_lat <= 1'b0;
      else if (w_advance)
        r_step_lat <= 1'b0;
      else if (w_step_rise)
        r_step_lat <= 1'b1;
      if (w_advance)
        r_frame <= r_frame + FRAME_W'(1);
    end
  end

  assign frame      = r_frame;
  assign part       = part_force_en ? part_force : r_frame[FRAME_W-1 -: PART_W];
  assign beat_phase = r_frame[5:4];
  assign envelope   = ENV_TOP - {r_frame[3:0], 1'b0};

`ifdef VGA_SEQ_SCANLINE_EN
  assign w_s0 = {vpos[0], w_hs0, w_vs0, display_on, rgb_in};
`else
  assign w_s0 = {w_hs0, w_vs0, display_on, rgb_in};
`endif

  generate
    if (PIPE == 0) begin : g_pipe_comb
      assign w_sn = w_s0;
    end else begin : g_pipe_reg
      logic [D_W-1:0] r_pipe [PIPE];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_s0;
          for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_sn = r_pipe[PIPE-1];
    end
  endgenerate

  assign w_rgb_vis = w_sn[RGB_W] ? w_sn[RGB_W-1:0] : '0;

`ifdef VGA_SEQ_SCANLINE_EN
  always_comb begin
    w_rgb_fin = w_rgb_vis;
    if (w_sn[RGB_W+3]) begin
      for (int c = 0; c < 3; c++)
        w_rgb_fin[c*BPC +: BPC] = w_rgb_vis[c*BPC +: BPC] >> 1;
    end
  end
`else
  assign w_rgb_fin = w_rgb_vis;
`endif

  // Gating with rst_n keeps pins quiet during reset even when PIPE is 0.
  assign hsync_o = (rst_n & w_sn[RGB_W+2]) ^ (SYNC_NEG != 0);
  assign vsync_o = (rst_n & w_sn[RGB_W+1]) ^ (SYNC_NEG != 0);
  assign rgb_o   = rst_n ? w_rgb_fin : '0;
endmodule

`default_nettype wire

// File: tb/tb_vga_demo_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_vga_demo_sequencer: directed checks on a 8x6-clock miniature raster.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_demo_sequencer;
  localparam int H_TOT = 8;
  localparam int V_TOT = 6;
  localparam int F_CLK = H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic       part_force_en = 1'b0;
  logic [2:0] part_force = 3'd0;
  logic [5:0] rgb_in;
  logic [9:0] hpos, vpos;
  logic       display_on, frame_start, hsync_o, vsync_o;
  logic [8:0] frame;
  logic [2:0] part;
  logic [1:0] beat_phase;
  logic [4:0] envelope;
  logic [5:0] rgb_o;

  int n_checks = 0;
  int n_fail   = 0;
  int bh = 0, bv = 0, ph = 0, pv = 0;
  bit pvalid = 1'b0;

  vga_demo_sequencer #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_NEG (1), .COORD_W (10), .BPC (2), .FRAME_W (9), .PART_W (3), .PIPE (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .pause (pause), .step (step),
    .part_force_en (part_force_en), .part_force (part_force), .rgb_in (rgb_in),
    .hpos (hpos), .vpos (vpos), .display_on (display_on), .frame_start (frame_start),
    .frame (frame), .part (part), .beat_phase (beat_phase), .envelope (envelope),
    .hsync_o (hsync_o), .vsync_o (vsync_o), .rgb_o (rgb_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pat(input int h, input int v);
    return {2'b11, 2'(h), 2'(v)};
  endfunction

  // Expected pins for the previous raster position (one pipeline stage).
  function automatic logic [5:0] exp_rgb(input int h, input int v, input bit valid);
    logic [5:0] x;
    if (!valid || !(h < 4 && v < 3)) return 6'd0;
    x = pat(h, v);
`ifdef VGA_SEQ_SCANLINE_EN
    if (v % 2 == 1) x = {1'b0, x[5], 1'b0, x[3], 1'b0, x[1]};
`endif
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      bh = 0; bv = 0; pvalid = 1'b0;
    end else begin
      ph = bh; pv = bv; pvalid = 1'b1;
      if (bh == H_TOT - 1) begin
        bh = 0;
        bv = (bv == V_TOT - 1) ? 0 : bv + 1;
      end else begin
        bh++;
      end
    end
    #2;
    rgb_in = pat(bh, bv);
  endtask

  task automatic run_frames(input int n);
    repeat (n * F_CLK) tick();
  endtask

  task automatic check_raster_frame();
    for (int i = 0; i < F_CLK; i++) begin
      check("hpos", 32'(hpos), 32'(bh));
      check("vpos", 32'(vpos), 32'(bv));
      check("hsync_o", 32'(hsync_o), 32'(!(pvalid && ph >= 5 && ph < 7)));
      check("vsync_o", 32'(vsync_o), 32'(!(pvalid && pv == 4)));
      check("rgb_o", 32'(rgb_o), 32'(exp_rgb(ph, pv, pvalid)));
      tick();
    end
  endtask

  initial begin
    rgb_in = pat(0, 0);
    repeat (3) tick();
    check("rst_hsync", 32'(hsync_o), 32'd1);
    check("rst_vsync", 32'(vsync_o), 32'd1);
    check("rst_rgb", 32'(rgb_o), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_frame_start", 32'(frame_start), 32'd1);

    check_raster_frame();
    check("frame_after_1", 32'(frame), 32'd1);
    check("fs_wrap", 32'(frame_start), 32'd1);
    check("env_f1", 32'(envelope), 32'd29);

    run_frames(14);
    check("frame_15", 32'(frame), 32'd15);
    check("env_f15", 32'(envelope), 32'd1);
    run_frames(33);
    check("beat_f48", 32'(beat_phase), 32'd3);
    check("env_f48", 32'(envelope), 32'd31);
    check("part_f48", 32'(part), 32'd0);
    run_frames(208);
    check("frame_256", 32'(frame), 32'h100);
    check("part_f256", 32'(part), 32'd4);
    part_force = 3'd5;
    part_force_en = 1'b1;
    #1;
    check("part_forced", 32'(part), 32'd5);
    check("frame_unforced", 32'(frame), 32'h100);
    part_force_en = 1'b0;
    #1;
    check("part_release", 32'(part), 32'd4);
    run_frames(255);
    check("frame_511", 32'(frame), 32'd511);
    check("part_f511", 32'(part), 32'd7);
    run_frames(1);
    check("frame_wrap", 32'(frame), 32'd0);
    check("part_wrap", 32'(part), 32'd0);

    pause = 1'b1;
    run_frames(3);
    check("paused_hold", 32'(frame), 32'd0);
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0; tick();
    repeat (F_CLK - 4) tick();
    check("step_twice", 32'(frame), 32'd1);
    run_frames(1);
    check("step_latch_clr", 32'(frame), 32'd1);
    repeat (F_CLK - 1) tick();
    check("at_frame_end_h", 32'(hpos), 32'(H_TOT - 1));
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_at_end", 32'(frame), 32'd2);

    pause = 1'b0;
    step = 1'b1; tick();
    step = 1'b0; tick();
    repeat (F_CLK - 2) tick();
    check("run_with_step", 32'(frame), 32'd3);
    pause = 1'b1;
    run_frames(1);
    check("step_discarded", 32'(frame), 32'd3);
    pause = 1'b0;

    repeat (2 * H_TOT + 3) tick();
    check("mid_hpos", 32'(hpos), 32'd3);
    check("mid_vpos", 32'(vpos), 32'd2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_hsync", 32'(hsync_o), 32'd1);
    check("mid_rst_rgb", 32'(rgb_o), 32'd0);
    check("mid_rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_hpos", 32'(hpos), 32'd0);
    check("mid_rel_vpos", 32'(vpos), 32'd0);
    check("mid_rel_fs", 32'(frame_start), 32'd1);
    check_raster_frame();
    check("post_mid_frame", 32'(frame), 32'd1);
    tick();
    check("fs_low", 32'(frame_start), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
